line_store_responder: RTL and testbench

LINE_STORE_RESPONDER -- requirements
Module: line_store_responder

---
 rtl/line_store_responder.sv | 163 ++++++++++++++++
 tb/tb_line_store_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_store_responder.sv
// rtl/line_store_responder.sv - line store: load stream, serve/write-back lines, dump stream.
// Optional stored-line parity: define LINE_STORE_PARITY_EN.
module line_store_responder #(
    parameter int SIZE    = 5,
    parameter int MEMSIZE = SIZE * SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MEMSIZE-1:0] in_data,
    input  logic               readLine,
    output logic [MEMSIZE-1:0] line,
    output logic               line_valid,
    output logic [5:0]         count,
    input  logic               write,
    input  logic [4:0]         waddr,
    input  logic [MEMSIZE-1:0] wdata,
    input  logic               finish,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MEMSIZE-1:0] out_data,
    output logic               loaded,
    output logic               done,
    output logic               dump_done
`ifdef LINE_STORE_PARITY_EN
    ,
    output logic               parity_err
`endif
);

    localparam int AW = 5;
    localparam logic [AW-1:0] LAST = AW'(MEMSIZE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE, DUMP} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d, optr_q, optr_d;
    logic [MEMSIZE-1:0]  line_q, line_d;
    logic                line_valid_q, line_valid_d;
    logic [5:0]          count_q, count_d;
    logic                done_q, done_d;

    logic [MEMSIZE-1:0]  mem [MEMSIZE];
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [MEMSIZE-1:0]  mem_wdata;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        optr_d       = optr_q;
        line_d       = line_q;
        line_valid_d = 1'b0;
        count_d      = count_q;
        done_d       = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = wptr_q;
        mem_wdata    = in_data;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    mem_we = 1'b1;
                    if (wptr_q == LAST) begin
                        state_d = SERVE;
                        rptr_d  = '0;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            SERVE: begin
                // Read samples mem before this edge's write lands: read-before-write.
                if (readLine) begin
                    line_d       = mem[rptr_q];
                    line_valid_d = 1'b1;
                    count_d      = {1'b0, rptr_q};
                    done_d       = (rptr_q == LAST);
                    rptr_d       = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
                end
                if (write && (waddr <= LAST)) begin
                    mem_we    = 1'b1;
                    mem_waddr = waddr;
                    mem_wdata = wdata;
                end
                if (finish) begin
                    state_d = DUMP;
                    optr_d  = '0;
                end
            end
            DUMP: begin
                if (out_ready) begin
                    if (optr_q == LAST) state_d = IDLE;
                    else                optr_d  = optr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            optr_q       <= '0;
            line_q       <= '0;
            line_valid_q <= 1'b0;
            count_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            optr_q       <= optr_d;
            line_q       <= line_d;
            line_valid_q <= line_valid_d;
            count_q      <= count_d;
            done_q       <= done_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign in_ready   = (state_q == LOAD);
    assign loaded     = (state_q == LOAD) && in_valid && (wptr_q == LAST);
    assign out_valid  = (state_q == DUMP);
    assign out_data   = out_valid ? mem[optr_q] : '0;
    assign dump_done  = out_valid && out_ready && (optr_q == LAST);
    assign line       = line_q;
    assign line_valid = line_valid_q;
    assign count      = count_q;
    assign done       = done_q;

`ifdef LINE_STORE_PARITY_EN
    logic par_mem [MEMSIZE];
    logic line_perr_q;

    always_ff @(posedge clk) begin
        if (mem_we) par_mem[mem_waddr] <= ^mem_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                line_perr_q <= 1'b0;
        else if ((state_q == SERVE) && readLine) line_perr_q <= (^mem[rptr_q]) ^ par_mem[rptr_q];
    end

    assign parity_err = (line_valid_q && line_perr_q) ||
                        (out_valid && ((^out_data) ^ par_mem[optr_q]));
`endif

endmodule

// File: tb/tb_line_store_responder.sv
// tb/tb_line_store_responder.sv - scoreboard bench for line_store_responder.
module tb_line_store_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, in_valid, in_ready;
    logic [24:0] in_data;
    logic        readLine;
    logic [24:0] line;
    logic        line_valid;
    logic [5:0]  count;
    logic        write;
    logic [4:0]  waddr;
    logic [24:0] wdata;
    logic        finish, out_valid, out_ready;
    logic [24:0] out_data;
    logic        loaded, done, dump_done;
`ifdef LINE_STORE_PARITY_EN
    logic        parity_err;
`endif

    line_store_responder dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .readLine(readLine), .line(line), .line_valid(line_valid), .count(count),
        .write(write), .waddr(waddr), .wdata(wdata), .finish(finish),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .loaded(loaded), .done(done), .dump_done(dump_done)
`ifdef LINE_STORE_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] l;
        logic [5:0]  c;
        logic        d;
        logic        p;
    } exp_t;

    exp_t        sbq[$];
    logic [24:0] exp_mem [25];
    int          rptr_m;
    int          total = 0;
    int          bad = 0;
    logic        perr_line3 = 1'b0;

    // Scoreboard: every line_valid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rst && line_valid) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_line_valid got line=%h count=%0d want none", line, count);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if ({line, count, done} !== {e.l, e.c, e.d}) begin
                    bad++;
                    $display("FAIL read_line got line=%h count=%0d done=%b want line=%h count=%0d done=%b",
                             line, count, done, e.l, e.c, e.d);
                end
`ifdef LINE_STORE_PARITY_EN
                total++;
                if (parity_err !== e.p) begin
                    bad++;
                    $display("FAIL parity_err count=%0d got %b want %b", count, parity_err, e.p);
                end
`endif
            end
        end
    end

    task automatic push_read();
        exp_t e;
        e.l = exp_mem[rptr_m];
        e.c = 6'(rptr_m);
        e.d = (rptr_m == 24);
        e.p = perr_line3 && (rptr_m == 3);
        sbq.push_back(e);
        rptr_m = (rptr_m + 1) % 25;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 0; in_valid = 0; in_data = 0; readLine = 0;
        write = 0; waddr = 0; wdata = 0; finish = 0; out_ready = 0;
        #1;
        total++;
        if ({in_ready, loaded, line_valid, done, out_valid, dump_done, count, line, out_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b ld=%b lv=%b cnt=%0d line=%h od=%h want all 0",
                     in_ready, loaded, line_valid, count, line, out_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic load_all(input int mul, input int add);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            in_valid = 1'b1;
            in_data  = 25'(i * mul + add);
            exp_mem[i] = in_data;
            @(negedge clk);
            total++;
            if ({in_ready, loaded} !== {1'b1, i == 24}) begin
                bad++;
                $display("FAIL load_handshake i=%0d got rdy=%b ld=%b want rdy=1 ld=%b", i, in_ready, loaded, i == 24);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rptr_m = 0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_exit in_ready got %b want 0", in_ready);
        end
    endtask

    task automatic do_reads(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 readLine = 1'b1;
            push_read();
        end
        @(posedge clk); #1 readLine = 1'b0;
    endtask

    task automatic read_with_write(input logic [4:0] wa, input logic [24:0] wd);
        @(posedge clk); #1;
        readLine = 1'b1; write = 1'b1; waddr = wa; wdata = wd;
        push_read();
        if (wa < 25) exp_mem[wa] = wd;
        @(posedge clk); #1;
        readLine = 1'b0; write = 1'b0;
    endtask

    task automatic test_serve();
        do_reads(26);
        do_reads(6);
        read_with_write(5'd7, 25'h1ABCDEF);
        read_with_write(5'd25, 25'h1FFFFFF);
        do_reads(24);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL serve_drain got %0d pending reads want 0", sbq.size());
        end
    endtask

    task automatic test_dump();
        @(posedge clk); #1 finish = 1'b1; readLine = 1'b1;
        push_read();
        @(posedge clk); #1 finish = 1'b0; readLine = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i % 3 == 1) begin
                out_ready = 1'b0;
                @(negedge clk);
                total++;
                if ({out_valid, out_data, dump_done} !== {1'b1, exp_mem[i], 1'b0}) begin
                    bad++;
                    $display("FAIL dump_stall i=%0d got v=%b d=%h dd=%b want v=1 d=%h dd=0",
                             i, out_valid, out_data, dump_done, exp_mem[i]);
                end
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(negedge clk);
            total++;
            if ({out_valid, out_data, dump_done} !== {1'b1, exp_mem[i], i == 24}) begin
                bad++;
                $display("FAIL dump_xfer i=%0d got v=%b d=%h dd=%b want v=1 d=%h dd=%b",
                         i, out_valid, out_data, dump_done, exp_mem[i], i == 24);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        total++;
        if ({out_valid, out_data, in_ready} !== '0) begin
            bad++;
            $display("FAIL dump_exit got v=%b d=%h rdy=%b want 0", out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_idle_ignore();
        readLine = 1'b1; write = 1'b1; waddr = 5'd0; wdata = 25'h1555555;
        in_valid = 1'b1; finish = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({in_ready, loaded, out_valid, dump_done} !== 4'b0) begin
                bad++;
                $display("FAIL idle_ignore got rdy=%b ld=%b ov=%b dd=%b want 0", in_ready, loaded, out_valid, dump_done);
            end
        end
        @(posedge clk); #1;
        readLine = 0; write = 0; in_valid = 0; finish = 0; out_ready = 0;
    endtask

    task automatic test_reset_mid_load();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 25'(100 + i);
            @(posedge clk); #1;
        end
        in_data = 25'd110;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({in_ready, loaded, line_valid, done, out_valid, dump_done, count, line, out_data} !== '0) begin
            bad++;
            $display("FAIL reset_mid_load got rdy=%b ld=%b lv=%b cnt=%0d line=%h want all 0",
                     in_ready, loaded, line_valid, count, line);
        end
        in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        load_all(5, 1);
        do_reads(25);
    endtask

    task automatic test_reset_mid_dump();
        @(posedge clk); #1 finish = 1'b1;
        @(posedge clk); #1 finish = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({out_valid, out_data, dump_done, line_valid, count} !== '0) begin
            bad++;
            $display("FAIL reset_mid_dump got v=%b d=%h dd=%b lv=%b cnt=%0d want all 0",
                     out_valid, out_data, dump_done, line_valid, count);
        end
        out_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_parity();
`ifdef LINE_STORE_PARITY_EN
        load_all(3, 0);
        dut.mem[3][0] = ~dut.mem[3][0];
        exp_mem[3][0] = ~exp_mem[3][0];
        perr_line3 = 1'b1;
        do_reads(5);
        repeat (2) @(posedge clk);
`endif
    endtask

    initial begin
        test_reset();
        load_all(3, 0);
        test_serve();
        test_dump();
        test_idle_ignore();
        test_reset_mid_load();
        test_reset_mid_dump();
        test_parity();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL final_drain got %0d pending reads want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
